// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-report bundle for the keypad scan controller.
// master: the scan controller (drives columns and key reports, reads rows).
// slave:  the keypad/application side.
interface keypad_scan_ctrl_if;
  logic [3:0] row_in;     // raw keypad rows, active-low, asynchronous
  logic [3:0] col_out;    // column drives, active-low, one-cold
  logic [3:0] key_code;   // {row, col} of the last accepted key
  logic       key_valid;  // one-cycle strobe per accepted press
  logic       key_held;   // high from accept until release is debounced

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low matrix keypad scanner with a single shared debounce counter.
// Columns are driven one at a time; when a row reads low at the end of a
// column dwell, the key is debounced, reported once, and then tracked until
// its release is debounced. Only one key is tracked at a time.
module keypad_scan_ctrl #(
  parameter int SCAN_TICKS     = 1000,    // dwell per column, >= 3
  parameter int DEBOUNCE_TICKS = 1000000  // stable cycles to accept, >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_scan_ctrl_if.master   kp
);

  localparam int DW = $clog2(SCAN_TICKS);
  localparam int BW = $clog2(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 32'sd1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_TICKS - 32'sd1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // One-cold column drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = ~(4'b0001 << c);
  endfunction

  logic [3:0]    sync1_r;
  logic [3:0]    rs_r;
  state_t        state_r;
  logic [DW-1:0] dwell_r;
  logic [BW-1:0] deb_r;
  logic [1:0]    col_r;
  logic [1:0]    row_r;
  logic [3:0]    col_out_r;
  logic [3:0]    key_code_r;
  logic          key_valid_r;
  logic          key_held_r;

  logic          any_low_s;
  logic [1:0]    low_row_s;
  logic          row_bit_s;
  logic [1:0]    next_col_s;

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 4'hF;
      rs_r    <= 4'hF;
    end else begin
      sync1_r <= kp.row_in;
      rs_r    <= sync1_r;
    end
  end

  // Lowest-index low row, the tracked row level and the next column index.
  always_comb begin
    any_low_s  = (rs_r != 4'hF);
    row_bit_s  = rs_r[row_r];
    next_col_s = col_r + 2'd1;
    if (!rs_r[0]) begin
      low_row_s = 2'd0;
    end else if (!rs_r[1]) begin
      low_row_s = 2'd1;
    end else if (!rs_r[2]) begin
      low_row_s = 2'd2;
    end else begin
      low_row_s = 2'd3;
    end
  end

  // Scan / debounce / hold / release state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_SCAN;
      dwell_r     <= {DW{1'b0}};
      deb_r       <= {BW{1'b0}};
      col_r       <= 2'd0;
      row_r       <= 2'd0;
      col_out_r   <= 4'b1110;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      case (state_r)
        ST_SCAN: begin
          if (dwell_r == DWELL_LAST) begin
            dwell_r <= {DW{1'b0}};
            if (any_low_s) begin
              // Stay on this column so {row, col} names the pressed key.
              row_r   <= low_row_s;
              deb_r   <= {BW{1'b0}};
              state_r <= ST_DEBOUNCE;
            end else begin
              col_r     <= next_col_s;
              col_out_r <= col_drive(next_col_s);
            end
          end else begin
            dwell_r <= dwell_r + DW'(1'b1);
          end
        end

        ST_DEBOUNCE: begin
          if (row_bit_s) begin
            // Bounce: give up on this key and move to the next column.
            deb_r     <= {BW{1'b0}};
            dwell_r   <= {DW{1'b0}};
            col_r     <= next_col_s;
            col_out_r <= col_drive(next_col_s);
            state_r   <= ST_SCAN;
          end else if (deb_r == DEB_LAST) begin
            key_code_r  <= {row_r, col_r};
            key_valid_r <= 1'b1;
            key_held_r  <= 1'b1;
            deb_r       <= {BW{1'b0}};
            state_r     <= ST_HELD;
          end else begin
            deb_r <= deb_r + BW'(1'b1);
          end
        end

        ST_HELD: begin
          if (row_bit_s) begin
            deb_r   <= {BW{1'b0}};
            state_r <= ST_RELEASE;
          end else begin
            deb_r <= {BW{1'b0}};
          end
        end

        ST_RELEASE: begin
          if (!row_bit_s) begin
            // Release bounce: key is still down, no new report.
            deb_r   <= {BW{1'b0}};
            state_r <= ST_HELD;
          end else if (deb_r == DEB_LAST) begin
            key_held_r <= 1'b0;
            deb_r      <= {BW{1'b0}};
            dwell_r    <= {DW{1'b0}};
            col_r      <= next_col_s;
            col_out_r  <= col_drive(next_col_s);
            state_r    <= ST_SCAN;
          end else begin
            deb_r <= deb_r + BW'(1'b1);
          end
        end

        default: begin
          state_r <= ST_SCAN;
          deb_r   <= {BW{1'b0}};
          dwell_r <= {DW{1'b0}};
        end
      endcase
    end
  end

  assign kp.col_out   = col_out_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule
